// File: rtl/res_out_reader.sv
// res_out_reader: drains res_out_fifo through a 2-entry skid buffer into framed valid/ready beats.
// Build option RES_OUT_READER_CHECKSUM_EN appends an XOR checksum beat to every frame.
module res_out_reader #(
    parameter int DATA_WIDTH       = 32,
    parameter int WORDS_PER_RESULT = 32,
    parameter int CNT_WIDTH        = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  frames_sent,
    output logic                  busy
);

    localparam logic [CNT_WIDTH-1:0] WPR = CNT_WIDTH'(WORDS_PER_RESULT);

    logic [DATA_WIDTH-1:0] skid_q [2];
    logic [DATA_WIDTH-1:0] skid_d [2];
    logic [1:0]            occ_q, occ_d, occ_after_pop;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic [CNT_WIDTH-1:0]  frames_q, frames_d;
    logic                  frame_done_q, frame_done_d;
    logic                  pop, push, push_csum, in_data, can_read;
    logic [DATA_WIDTH-1:0] push_word;

    assign tx_valid      = (occ_q != 2'd0);
    assign tx_data       = skid_q[0];
    assign pop           = tx_valid && tx_ready;
    assign occ_after_pop = occ_q - {1'b0, pop};
    assign push          = inflight_q || push_csum;
    assign inflight_d    = fifo_rd_en;

    // Space must exist for the word already in flight plus the new one.
    assign can_read   = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    // rst_n gates the request so the FIFO sees no pop while the block is held in reset.
    assign fifo_rd_en = rst_n && !fifo_empty && in_data && (issued_q < WPR) && can_read;

    assign busy        = (occ_q != 2'd0) || inflight_q || !(in_data && (issued_q == '0));
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_q;

`ifdef RES_OUT_READER_CHECKSUM_EN
    typedef enum logic {ST_DATA = 1'b0, ST_CSUM = 1'b1} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [1:0]            tag_q, tag_d;   // marks which buffer entry holds the checksum

    assign in_data   = (state_q == ST_DATA);
    assign push_csum = (state_q == ST_CSUM) && !inflight_q && (occ_after_pop < 2'd2);
    assign push_word = push_csum ? csum_q : fifo_dout;
    assign tx_last   = tx_valid && tag_q[0];

    always_comb begin
        state_d  = state_q;
        csum_d   = csum_q;
        issued_d = issued_q;
        if (inflight_q) csum_d = csum_q ^ fifo_dout;
        if (fifo_rd_en) issued_d = issued_q + CNT_WIDTH'(1);
        if (state_q == ST_DATA) begin
            if (issued_d == WPR) state_d = ST_CSUM;
        end else if (push_csum) begin
            state_d  = ST_DATA;
            issued_d = '0;
            csum_d   = '0;
        end
    end

    always_comb begin
        tag_d = tag_q;
        if (pop) tag_d = {1'b0, tag_q[1]};
        if (push) tag_d[occ_after_pop[0]] = push_csum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
            csum_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            csum_q  <= csum_d;
            tag_q   <= tag_d;
        end
    end
`else
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORDS_PER_RESULT - 1);

    assign in_data   = 1'b1;
    assign push_csum = 1'b0;
    assign push_word = fifo_dout;
    assign tx_last   = tx_valid && (sent_q == LAST_IDX);

    always_comb begin
        issued_d = issued_q;
        if (fifo_rd_en) issued_d = (issued_q == LAST_IDX) ? '0 : issued_q + CNT_WIDTH'(1);
    end
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        skid_d = skid_q;
        occ_d  = occ_after_pop;
        if (pop) skid_d[0] = skid_q[1];
        if (push) begin
            skid_d[occ_after_pop[0]] = push_word;
            occ_d = occ_after_pop + 2'd1;
        end
    end

    always_comb begin
        sent_d       = sent_q;
        frames_d     = frames_q;
        frame_done_d = 1'b0;
        if (pop) begin
            if (tx_last) begin
                sent_d       = '0;
                frames_d     = frames_q + CNT_WIDTH'(1);
                frame_done_d = 1'b1;
            end else begin
                sent_d = sent_q + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two buffer entries are reset because they drive tx_data, which must read 0 in reset.
            skid_q[0]    <= '0;
            skid_q[1]    <= '0;
            occ_q        <= '0;
            inflight_q   <= 1'b0;
            issued_q     <= '0;
            sent_q       <= '0;
            frames_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            frames_q     <= frames_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_res_out_reader.sv
// Directed bench for res_out_reader: FIFO model, beat monitor and one task per scenario.
// Expected streams come from a word-level frame model that adds the XOR beat when RES_OUT_READER_CHECKSUM_EN is set.
module tb_res_out_reader;

    localparam int DW = 32;
    localparam int W  = 4;
    localparam int CW = 6;
`ifdef RES_OUT_READER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tx_ready = 1'b0;
    logic          fifo_empty, fifo_rd_en, tx_valid, tx_last, frame_done, busy;
    logic [DW-1:0] fifo_dout, tx_data;
    logic [CW-1:0] frames_sent;

    int n_checks = 0;
    int n_fail   = 0;

    res_out_reader #(.DATA_WIDTH(DW), .WORDS_PER_RESULT(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_last(tx_last), .frame_done(frame_done), .frames_sent(frames_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: data one cycle after an accepted read, zero otherwise; cleared by the system reset.
    logic [DW-1:0] fifo_mem [0:511];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 0;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end else begin
            fifo_dout <= '0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Beat monitor: logs accepted beats and tallies protocol violations.
    logic [DW-1:0] got_data [$];
    bit            got_last [$];
    int            got_cyc  [$];
    int rd_count, data_pops, done_count, stab_err, ovf_err, empty_rd_err;
    int first_rd_cyc, first_valid_cyc;
    logic          prev_stall, prev_last;
    logic [DW-1:0] prev_data;
    logic          pop_now, pop_data;

    assign pop_now  = tx_valid && tx_ready;
    assign pop_data = pop_now && !(CSUM && tx_last);

    always @(negedge clk) begin
        if (!rst_n) begin
            got_data.delete(); got_last.delete(); got_cyc.delete();
            rd_count <= 0; data_pops <= 0; done_count <= 0;
            stab_err <= 0; ovf_err <= 0; empty_rd_err <= 0;
            first_rd_cyc <= -1; first_valid_cyc <= -1;
            prev_stall <= 1'b0; prev_last <= 1'b0; prev_data <= '0;
        end else begin
            if (fifo_rd_en && fifo_empty) empty_rd_err <= empty_rd_err + 1;
            if (fifo_rd_en && (rd_count - data_pops - int'(pop_data)) >= 2) ovf_err <= ovf_err + 1;
            if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last))
                stab_err <= stab_err + 1;
            if (fifo_rd_en) rd_count <= rd_count + 1;
            if (pop_data) data_pops <= data_pops + 1;
            if (frame_done) done_count <= done_count + 1;
            if (first_rd_cyc < 0 && fifo_rd_en) first_rd_cyc <= cyc;
            if (first_valid_cyc < 0 && tx_valid) first_valid_cyc <= cyc;
            if (pop_now) begin
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_cyc.push_back(cyc);
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
            prev_last  <= tx_last;
        end
    end

    // Expected-stream model.
    logic [DW-1:0] exp_data [$];
    bit            exp_last [$];
    int            word_idx = 0;
    logic [DW-1:0] acc = '0;

    task automatic push_word(input logic [DW-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        acc = acc ^ w;
        exp_data.push_back(w);
        if (word_idx == W - 1) begin
            if (CSUM) begin
                exp_last.push_back(1'b0);
                exp_data.push_back(acc);
                exp_last.push_back(1'b1);
            end else begin
                exp_last.push_back(1'b1);
            end
            acc = '0;
            word_idx = 0;
        end else begin
            exp_last.push_back(1'b0);
            word_idx = word_idx + 1;
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic apply_reset();
        drive_edge();
        rst_n = 1'b0;
        tx_ready = 1'b0;
        wr_ptr = 0;
        word_idx = 0;
        acc = '0;
        exp_data.delete();
        exp_last.delete();
        repeat (2) drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [DW+CW+4:0] all_out;
        #2 rst_n = 1'b0;
        drive_edge();
        for (int i = 1; i <= 4; i++) push_word(DW'(i));
        sample();
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_checks++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL reset_tx_last: got %b want 0", tx_last); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (frames_sent !== '0) begin n_fail++; $display("FAIL reset_frames_sent: got %0d want 0", frames_sent); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        drive_edge();
        rst_n = 1'b1;
        sample();
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL release_rd_en: got %b want 1", fifo_rd_en); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid_n0: got %b want 0", tx_valid); end
        sample();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid_n1: got %b want 0", tx_valid); end
        sample();
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid_n2: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== 32'h1) begin n_fail++; $display("FAIL release_first_beat: got %h want 1", tx_data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL release_busy: got %b want 1", busy); end
        drive_edge();
        rst_n = 1'b0;
        #1;
        all_out = {fifo_rd_en, tx_valid, tx_data, tx_last, frame_done, frames_sent, busy};
        n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL midstream_reset_outputs: got %h want 0", all_out); end
        wr_ptr = 0;
        repeat (2) drive_edge();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset();
        tx_ready = 1'b1;
        drive_edge();
        for (int i = 0; i < 8; i++) push_word(32'h11 + DW'(i));
        for (int k = 0; k < 60 && got_data.size() < exp_data.size(); k++) sample();
        n_checks++; if (got_data.size() != exp_data.size()) begin n_fail++; $display("FAIL stream_count: got %0d want %0d", got_data.size(), exp_data.size()); end
        n_checks++; if (first_valid_cyc - first_rd_cyc != 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_valid_cyc - first_rd_cyc); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL stream_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
`ifndef RES_OUT_READER_CHECKSUM_EN
        n_checks++; if (got_cyc.size() == 8 && got_cyc[7] - got_cyc[0] != 7) begin n_fail++; $display("FAIL stream_throughput: got span %0d want 7", got_cyc[7] - got_cyc[0]); end
`endif
        repeat (3) sample();
        n_checks++; if (frames_sent !== 6'd2) begin n_fail++; $display("FAIL stream_frames_sent: got %0d want 2", frames_sent); end
        n_checks++; if (done_count != 2) begin n_fail++; $display("FAIL stream_frame_done: got %0d want 2", done_count); end
    endtask

    task automatic test_checksum();
        apply_reset();
        tx_ready = 1'b1;
        drive_edge();
        push_word(32'h1); push_word(32'h2); push_word(32'h4); push_word(32'h8);
        for (int k = 0; k < 40 && got_data.size() < exp_data.size(); k++) sample();
        n_checks++; if (got_data.size() != exp_data.size()) begin n_fail++; $display("FAIL csum_count: got %0d want %0d", got_data.size(), exp_data.size()); end
`ifdef RES_OUT_READER_CHECKSUM_EN
        n_checks++; if (got_data.size() > 4 && (got_data[4] !== 32'hF || got_last[4] !== 1'b1)) begin n_fail++; $display("FAIL csum_beat: got %h/%b want f/1", got_data[4], got_last[4]); end
`else
        n_checks++; if (got_data.size() > 3 && (got_data[3] !== 32'h8 || got_last[3] !== 1'b1)) begin n_fail++; $display("FAIL csum_last_data: got %h/%b want 8/1", got_data[3], got_last[3]); end
`endif
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL csum_stream[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        repeat (3) sample();
        n_checks++; if (done_count != 1) begin n_fail++; $display("FAIL csum_frame_done: got %0d want 1", done_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive_edge();
        for (int i = 0; i < 32; i++) push_word(32'hA500_0000 | (DW'(i) * 32'h111));
        for (int k = 0; k < 400 && got_data.size() < exp_data.size(); k++) begin
            drive_edge();
            tx_ready = (k % 4 == 0) || (k % 4 == 3);
        end
        drive_edge();
        tx_ready = 1'b1;
        repeat (3) sample();
        n_checks++; if (got_data.size() != exp_data.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL bp_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations want 0", stab_err); end
        n_checks++; if (ovf_err != 0) begin n_fail++; $display("FAIL bp_overread: got %0d violations want 0", ovf_err); end
        n_checks++; if (empty_rd_err != 0) begin n_fail++; $display("FAIL bp_empty_read: got %0d want 0", empty_rd_err); end
        n_checks++; if (frames_sent !== 6'd8) begin n_fail++; $display("FAIL bp_frames_sent: got %0d want 8", frames_sent); end
    endtask

    task automatic test_empty_fifo();
        apply_reset();
        tx_ready = 1'b1;
        repeat (10) sample();
        n_checks++; if (rd_count != 0) begin n_fail++; $display("FAIL empty_no_read: got %0d reads want 0", rd_count); end
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL empty_idle: got valid %b busy %b want 0 0", tx_valid, busy); end
        drive_edge();
        push_word(32'h3C);
        sample();
        n_checks++; if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL empty_single_rd: got %b want 1", fifo_rd_en); end
        sample();
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL empty_single_n1: got %b want 0", tx_valid); end
        sample();
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 32'h3C) begin n_fail++; $display("FAIL empty_single_beat: got %b/%h want 1/3c", tx_valid, tx_data); end
        sample();
        n_checks++; if (tx_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL empty_drained: got valid %b rd %b want 0 0", tx_valid, fifo_rd_en); end
        n_checks++; if (empty_rd_err != 0) begin n_fail++; $display("FAIL empty_read_violation: got %0d want 0", empty_rd_err); end
    endtask

    task automatic test_counter_wrap();
        int k;
        apply_reset();
        tx_ready = 1'b1;
        drive_edge();
        for (int i = 0; i < 64 * W; i++) push_word(DW'(i) ^ 32'h0F0F_0000);
        for (k = 0; k < 3000 && frames_sent !== 6'd63; k++) sample();
        n_checks++; if (frames_sent !== 6'd63 || frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_at_63: got %0d/%b want 63/1", frames_sent, frame_done); end
        for (k = 0; k < 100 && frames_sent === 6'd63; k++) sample();
        n_checks++; if (frames_sent !== 6'd0 || frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_to_0: got %0d/%b want 0/1", frames_sent, frame_done); end
        n_checks++; if (done_count != 64) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 64", done_count); end
        n_checks++; if (got_data.size() != exp_data.size()) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                n_fail++; $display("FAIL wrap_beat[%0d]: got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_checksum();
        test_backpressure();
        test_empty_fifo();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/res_out_reader.md
# res_out_reader

Drain engine for the modular-exponentiation result path. It pops words from `res_out_fifo` using that FIFO's read protocol: `rd_en` gated by `empty`, with data valid one cycle later and zero otherwise. It re-times the words through a 2-entry skid buffer and presents them as framed valid/ready beats to the host-side link. Each result is one frame of `WORDS_PER_RESULT` words, optionally followed by a checksum word.

## Interface
- `DATA_WIDTH`, 32, word width; must match the FIFO.
- `WORDS_PER_RESULT`, 32, data words per result frame (1024-bit result); legal range is 1..2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, 6, width of the word and frame counters.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  `DATA_WIDTH`  FIFO read data; valid the cycle after an accepted `fifo_rd_en`.
- `fifo_rd_en`  out  1  FIFO pop request.
- `tx_ready`  in  1  downstream accepts the current beat.
- `tx_valid`  out  1  beat valid.
- `tx_data`  out  `DATA_WIDTH`  beat payload.
- `tx_last`  out  1  final beat of the frame.
- `frame_done`  out  1  one-cycle pulse when the `tx_last` beat is accepted.
- `frames_sent`  out  `CNT_WIDTH`  count of completed frames; wraps modulo 2^`CNT_WIDTH`.
- `busy`  out  1  high when the buffer is non-empty, a read is in flight, or the FSM is not in DATA with `issued==0`.

## Operation
- **Reset values.** While `rst_n` is low, every output is 0. `fifo_rd_en`, `tx_valid`, `tx_data`, `tx_last`, `frame_done`, `frames_sent` and `busy` are all 0. The buffer is emptied, all counters are cleared, and the FSM is in DATA.
- **In-flight flag.** `inflight` is `fifo_rd_en` registered.
- **Capture.** When `inflight` is 1, `fifo_dout` is written into the buffer tail at that edge.
- **Buffer occupancy.** `occ` is 0..2.
- **Pop.** A pop is `tx_valid && tx_ready`.
- **Read issue rule.** `fifo_rd_en = !fifo_empty && state==DATA && issued<WORDS_PER_RESULT && (occ + inflight - pop) < 2`. This is combinational. The buffer can therefore never overflow, and the FIFO is never read while empty.
- **Issued counter.** `issued` counts accepted reads in the current frame.
- **Output counter.** `sent` counts popped data beats in the current frame.
- **Last flag.** `tx_last` is 1 on the beat whose `sent == WORDS_PER_RESULT-1` (without checksum) or on the checksum beat (with checksum).
- **FSM (checksum enabled): DATA → CSUM → DATA.**
  - DATA → CSUM when `issued` reaches `WORDS_PER_RESULT`.
  - In CSUM, the checksum is enqueued as a buffer entry on the first cycle that satisfies both conditions: `inflight==0`, and `occ - pop < 2`. Once enqueued, go to DATA, clear `issued`, and clear the checksum accumulator.
- **FSM (checksum disabled).** DATA only. `issued` clears on the read that reaches `WORDS_PER_RESULT`.
- **Frame completion.** On acceptance of the `tx_last` beat:
  - `frame_done` pulses the following cycle.
  - `frames_sent` increments.
  - `sent` clears.
- **Reset mid-frame.** The partial frame and any in-flight FIFO word are discarded. The FIFO is reset by the same system reset (inverted for its active-high `rst`).

## Timing
- **Read-to-output latency.** `fifo_rd_en` at cycle N → capture at the end of N+1 → `tx_valid` at N+2.
- **Throughput.** 1 word/cycle sustained while `tx_ready` is held high and the FIFO is non-empty.
- **Beat stability.** Once `tx_valid` is 1, `tx_data` and `tx_last` stay stable until the beat is accepted. `tx_valid` does not drop without an accept.
- **Simultaneous events.** A pop and a capture in the same cycle leave `occ` unchanged.
- **Read while full.** Reading with `occ==2` is allowed only if a pop occurs in that cycle.
- **Empty FIFO.** When `fifo_empty` is 1, `fifo_rd_en` is 0 in the same cycle. The buffer drains and `tx_valid` falls after the last entry is popped.

## Configuration
- **Macro:** `RES_OUT_READER_CHECKSUM_EN`.
- **Defined:**
  - The CSUM state is built.
  - The accumulator XORs each captured data word.
  - A trailing beat carries the XOR of all `WORDS_PER_RESULT` words.
  - A frame is `WORDS_PER_RESULT+1` beats, with `tx_last` on the checksum beat.
- **Undefined:**
  - No accumulator and no CSUM state.
  - A frame is `WORDS_PER_RESULT` beats, with `tx_last` on the final data word.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream → all outputs read 0 immediately. After release, with the FIFO holding 1..4, the first beat is 1.
- **Streaming, no checksum.** `WORDS_PER_RESULT`=4, FIFO preloaded with 0x11..0x18, `tx_ready`=1 →
  - beats 0x11..0x18 on 8 consecutive cycles, with the first `tx_valid` 2 cycles after the first `fifo_rd_en`;
  - `tx_last` on 0x14 and 0x18;
  - `frames_sent`=2.
- **Checksum.** Define `RES_OUT_READER_CHECKSUM_EN`, `WORDS_PER_RESULT`=4, data 0x1, 0x2, 0x4, 0x8 → fifth beat is 0xF with `tx_last`=1, and `frame_done` pulses once.
- **Backpressure.** Toggle `tx_ready` 1,0,0,1 over a 32-word frame →
  - no word lost or duplicated;
  - `fifo_rd_en` is never asserted when `occ+inflight` would exceed 2;
  - `tx_data` is stable while stalled.
- **Empty FIFO.** With `fifo_empty`=1 throughout, `fifo_rd_en` is never 1. A single word written later appears 2 cycles after its `fifo_rd_en`.
- **Counter wrap.** 64 frames with `CNT_WIDTH`=6 → `frames_sent` wraps 63→0.
